// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: head register plus optional skid register, with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer; otherwise a single entry is held.
module pipe_stage_buf #(
  parameter int unsigned DATA_W          = 96,
  parameter int unsigned CTRL_W          = 12,
  parameter int unsigned FLUSH_DATA_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              head_valid, accept, consume;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
`endif

  assign head_valid = (state_q != StEmpty);
  assign accept     = in_valid && in_ready;
  assign consume    = head_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      stall_cnt_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
`endif
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d     = StOne;
          head_ctrl_d = in_ctrl;
          head_data_d = in_data;
        end
      end
      StOne: begin
        if (accept && consume) begin
          head_ctrl_d = in_ctrl;
          head_data_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
        end else if (accept) begin
          state_d     = StFull;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
`endif
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      StFull: begin
        if (consume) begin
          state_d     = StOne;
          head_ctrl_d = skid_ctrl_q;
          head_data_d = skid_data_q;
        end
      end
`endif
      default: state_d = StEmpty;
    endcase

    // Flush wins over any accept/consume decided above.
    if (flush) begin
      state_d     = StEmpty;
      head_ctrl_d = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_d = '0;
`endif
      if (FLUSH_DATA_ZERO != 0) begin
        head_data_d = '0;
`ifdef PIPE_STAGE_SKID_EN
        skid_data_d = '0;
`endif
      end
    end

`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != StFull);
`endif

    stall_cnt_d = stall_cnt_q;
    if (head_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_comb begin
    out_valid = head_valid;
    out_ctrl  = head_valid ? head_ctrl_q : '0;
    out_data  = head_data_q;
    stall_cnt = stall_cnt_q;
    case (state_q)
      StOne:   level = 2'd1;
      StFull:  level = 2'd2;
      default: level = 2'd0;
    endcase
`ifdef PIPE_STAGE_SKID_EN
    in_ready = in_ready_q;
`else
    in_ready = !head_valid || out_ready;
`endif
  end

endmodule
